// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor: counter encoding,
// BTB entry layout and the saturating-counter update rule.
package bp_pkg;

  localparam int DEF_PHT_BITS = 6;
  localparam int DEF_BTB_BITS = 4;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt_t;

  localparam cnt_t CNT_RESET = WNT;

  // Tag holds the whole word address; the index bits always match on a lookup,
  // so comparing all of them is the same as comparing the true tag.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
  } btb_entry_t;

  function automatic cnt_t cnt_update(cnt_t c, logic taken);
    cnt_t n;
    unique case (c)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      default: n = taken ? ST  : WT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: one combinational read port for fetch,
// one write port for resolved taken branches, asynchronous clear.
module bp_btb
  import bp_pkg::*;
#(
  parameter int BTB_BITS = DEF_BTB_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] rd_word,
  output logic        rd_hit,
  output logic [31:0] rd_target,
  input  logic        wr_en,
  input  logic [29:0] wr_word,
  input  logic [31:0] wr_target
);

  localparam int ENTRIES = 1 << BTB_BITS;

  btb_entry_t entries [ENTRIES];
  btb_entry_t rd_entry;

  assign rd_entry  = entries[rd_word[BTB_BITS-1:0]];
  assign rd_hit    = rd_entry.valid && (rd_entry.tag == rd_word);
  assign rd_target = rd_entry.target;

  // NOTE: the table is built from flops, so every entry is cleared by reset;
  // a RAM-based table could not be reset this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
    end else if (wr_en) begin
      // NOTE: state is written with non-blocking assignments so every flop
      // samples pre-edge values regardless of process order.
      entries[wr_word[BTB_BITS-1:0]] <= '{valid: 1'b1, tag: wr_word, target: wr_target};
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor with BTB target lookup at fetch, and
// non-speculative training plus misprediction detection at memory stage.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PHT_BITS = DEF_PHT_BITS,
  parameter int BTB_BITS = DEF_BTB_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pcF,
  output logic                predict_takeF,
  output logic [31:0]         predict_targetF,
  output logic [PHT_BITS-1:0] predict_idxF,
  input  logic                branchM,
  input  logic                actually_takenM,
  input  logic [31:0]         pcM,
  input  logic [31:0]         branch_targetM,
  input  logic                predict_takeM,
  input  logic [31:0]         predict_targetM,
  input  logic [PHT_BITS-1:0] predict_idxM,
  output logic                predict_resultM,
  output logic                mispredictM,
  output logic [31:0]         redirect_pcM,
  output logic [15:0]         branch_count,
  output logic [15:0]         mispredict_count
);

  localparam int PHT_SIZE = 1 << PHT_BITS;

  cnt_t                pht [PHT_SIZE];
  logic [PHT_BITS-1:0] ghr;
  logic [15:0]         br_cnt;
  logic [15:0]         mp_cnt;
  logic                btb_hit;
  logic [31:0]         btb_target;
  cnt_t                cur_cnt;
  logic                pc_align_unused;

  // Fetch PCs are word aligned; the byte-offset bits carry no information.
  assign pc_align_unused = ^pcF[1:0];

  bp_btb #(.BTB_BITS(BTB_BITS)) u_btb (
    .clk       (clk),
    .rst_n     (rst),
    .rd_word   (pcF[31:2]),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .wr_en     (branchM && actually_takenM),
    .wr_word   (pcM[31:2]),
    .wr_target (branch_targetM)
  );

  assign predict_idxF    = pcF[PHT_BITS+1:2] ^ ghr;
  assign cur_cnt         = pht[predict_idxF];
  assign predict_takeF   = btb_hit && (cur_cnt inside {WT, ST});
  assign predict_targetF = predict_takeF ? btb_target : '0;

  assign predict_resultM = branchM && (predict_takeM == actually_takenM) &&
                           (!actually_takenM || (predict_targetM == branch_targetM));
  assign mispredictM     = branchM && !predict_resultM;
  assign redirect_pcM    = actually_takenM ? branch_targetM : pcM + 32'd4;

  // Training uses the index carried from fetch; the GHR may have shifted since.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHT_SIZE; i++) pht[i] <= CNT_RESET;
      ghr    <= '0;
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (branchM) begin
      pht[predict_idxM] <= cnt_update(pht[predict_idxM], actually_takenM);
      ghr               <= {ghr[PHT_BITS-2:0], actually_takenM};
      br_cnt            <= br_cnt + 16'd1;
      if (mispredictM) mp_cnt <= mp_cnt + 16'd1;
    end
  end

  assign branch_count     = br_cnt;
  assign mispredict_count = mp_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed literal cases plus randomized traffic compared
// every cycle against an array-based model of the predictor.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic        predict_takeF;
  logic [31:0] predict_targetF;
  logic [5:0]  predict_idxF;
  logic        branchM, actually_takenM, predict_takeM;
  logic [31:0] pcM, branch_targetM, predict_targetM;
  logic [5:0]  predict_idxM;
  logic        predict_resultM, mispredictM;
  logic [31:0] redirect_pcM;
  logic [15:0] branch_count, mispredict_count;

  always #5 clk = ~clk;

  branch_predictor #(.PHT_BITS(6), .BTB_BITS(4)) dut (
    .clk(clk), .rst(rst), .pcF(pcF),
    .predict_takeF(predict_takeF), .predict_targetF(predict_targetF),
    .predict_idxF(predict_idxF), .branchM(branchM),
    .actually_takenM(actually_takenM), .pcM(pcM), .branch_targetM(branch_targetM),
    .predict_takeM(predict_takeM), .predict_targetM(predict_targetM),
    .predict_idxM(predict_idxM), .predict_resultM(predict_resultM),
    .mispredictM(mispredictM), .redirect_pcM(redirect_pcM),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counters as integers 0..3, BTB as full-PC slots.
  int          m_pht [64];
  int          m_ghr;
  bit          m_v   [16];
  logic [31:0] m_pc  [16];
  logic [31:0] m_tgt [16];
  int          m_bc, m_mc;

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_pht[i] = 1;
    for (int i = 0; i < 16; i++) m_v[i] = 0;
    m_ghr = 0;
    m_bc  = 0;
    m_mc  = 0;
  endtask

  function automatic int m_index(logic [31:0] pc);
    return (int'((pc / 4) % 64) ^ m_ghr) % 64;
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int s = int'((pc / 4) % 16);
    return m_v[s] && ((m_pc[s] / 64) == (pc / 64));
  endfunction

  function automatic bit m_take(logic [31:0] pc);
    return m_hit(pc) && (m_pht[m_index(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(logic [31:0] pc);
    return m_take(pc) ? m_tgt[int'((pc / 4) % 16)] : 32'd0;
  endfunction

  function automatic bit m_correct();
    return branchM && (predict_takeM == actually_takenM) &&
           (!actually_takenM || predict_targetM == branch_targetM);
  endfunction

  always @(posedge clk) begin
    if (rst === 1'b1 && branchM === 1'b1) begin
      int i;
      int s;
      bit ok;
      ok = m_correct();
      i  = int'(predict_idxM);
      if (actually_takenM) begin
        if (m_pht[i] < 3) m_pht[i]++;
      end else if (m_pht[i] > 0) m_pht[i]--;
      m_ghr = ((m_ghr * 2) + int'(actually_takenM)) % 64;
      if (actually_takenM) begin
        s = int'((pcM / 4) % 16);
        m_v[s]   = 1;
        m_pc[s]  = pcM;
        m_tgt[s] = branch_targetM;
      end
      m_bc = (m_bc + 1) % 65536;
      if (!ok) m_mc = (m_mc + 1) % 65536;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst === 1'b1) begin
      check("takeF",    predict_takeF,    m_take(pcF));
      check("targetF",  predict_targetF,  m_target(pcF));
      check("idxF",     predict_idxF,     m_index(pcF));
      check("resultM",  predict_resultM,  m_correct());
      check("mispM",    mispredictM,      branchM && !m_correct());
      check("redirect", redirect_pcM,     actually_takenM ? branch_targetM : pcM + 32'd4);
      check("br_cnt",   branch_count,     m_bc);
      check("mp_cnt",   mispredict_count, m_mc);
    end
  end

  task automatic drive_m(bit br, logic [31:0] pc, logic [31:0] tgt, bit act,
                         bit ptake, logic [31:0] ptgt, int pidx);
    branchM         = br;
    pcM             = pc;
    branch_targetM  = tgt;
    actually_takenM = act;
    predict_takeM   = ptake;
    predict_targetM = ptgt;
    predict_idxM    = pidx[5:0];
  endtask

  logic [31:0] pool [8] = '{32'h40, 32'h44, 32'hA8, 32'h100,
                            32'h180, 32'h200, 32'h1040, 32'h2040};

  task automatic rand_cycle(bit force_br);
    logic [31:0] pc, tgt, ptg;
    bit          br, act, pt;
    int          pi;
    @(posedge clk); #1;
    pcF = pool[$urandom % 8];
    br  = force_br || ($urandom % 10 < 4);
    pc  = pool[$urandom % 8];
    act = ($urandom % 4) != 0;
    tgt = ($urandom % 16 == 0) ? pool[$urandom % 8] + 32'h1000 : pc + 32'h100;
    if ($urandom % 4 != 0) begin
      pt  = m_take(pc);
      ptg = m_target(pc);
      pi  = m_index(pc);
    end else begin
      pt  = $urandom % 2;
      ptg = pt ? pc + 32'h100 : 32'd0;
      pi  = $urandom % 64;
    end
    drive_m(br, pc, tgt, act, pt, ptg, pi);
  endtask

  initial begin
    rst = 1'b0;
    pcF = 32'd0;
    drive_m(0, 0, 0, 0, 0, 0, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    cmp_en = 1;
    pcF    = 32'h40;
    #1;
    check("rst_takeF",   predict_takeF,   0);
    check("rst_targetF", predict_targetF, 0);
    check("rst_idxF",    predict_idxF,    6'h10);
    check("rst_br_cnt",  branch_count,    0);
    check("rst_mispM",   mispredictM,     0);
    check("rst_resultM", predict_resultM, 0);

    // First resolve of the 0x40 branch: cold predictor guessed not taken.
    @(posedge clk); #1;
    drive_m(1, 32'h40, 32'h80, 1, 0, 0, 16);
    #1;
    check("first_misp",  mispredictM,  1);
    check("first_redir", redirect_pcM, 32'h80);

    // Six not-taken branches elsewhere shift the GHR back to zero.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      drive_m(1, 32'h300, 32'h400, 0, 0, 0, 40);
    end
    @(posedge clk); #1;
    drive_m(0, 0, 0, 0, 0, 0, 0);
    pcF = 32'h40;
    #1;
    check("trained_take", predict_takeF,   1);
    check("trained_tgt",  predict_targetF, 32'h80);
    check("trained_idx",  predict_idxF,    16);

    @(posedge clk); #1;
    drive_m(1, 32'h40, 32'h80, 1, 1, 32'h80, 16);
    #1;
    check("second_ok",   predict_resultM, 1);
    check("second_misp", mispredictM,     0);

    // Saturation at index 20: four taken, one not taken leaves weak-taken.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      drive_m(1, 32'hA8, 32'h500, 1, 0, 0, 20);
    end
    @(posedge clk); #1;
    drive_m(1, 32'hA8, 32'h500, 0, 0, 0, 20);
    @(posedge clk); #1;
    drive_m(0, 0, 0, 0, 0, 0, 0);
    pcF = 32'hA8;
    #1;
    check("sat_idx",  predict_idxF,    20);
    check("sat_take", predict_takeF,   1);
    check("sat_tgt",  predict_targetF, 32'h500);

    @(posedge clk); #1;
    drive_m(1, 32'h100, 32'h140, 0, 1, 32'h140, 50);
    #1;
    check("nt_misp",  mispredictM,  1);
    check("nt_redir", redirect_pcM, 32'h104);

    // Target mismatch; the same-cycle fetch still sees the old BTB slot.
    @(posedge clk); #1;
    drive_m(1, 32'h180, 32'h240, 1, 1, 32'h200, 25);
    pcF = 32'h180;
    #1;
    check("tm_misp",     mispredictM,   1);
    check("tm_redir",    redirect_pcM,  32'h240);
    check("tm_old_take", predict_takeF, 0);
    @(posedge clk); #1;
    drive_m(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("tm_idx",  predict_idxF,    25);
    check("tm_take", predict_takeF,   1);
    check("tm_tgt",  predict_targetF, 32'h240);

    for (int k = 0; k < 3000; k++) rand_cycle(0);

    // Asynchronous reset in the middle of an update cycle.
    @(posedge clk); #1;
    drive_m(1, 32'h40, 32'h80, 1, 0, 0, 16);
    pcF = 32'h40;
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    check("ar_br_cnt", branch_count,     0);
    check("ar_mp_cnt", mispredict_count, 0);
    check("ar_take",   predict_takeF,    0);
    check("ar_tgt",    predict_targetF,  0);
    check("ar_idx",    predict_idxF,     16);
    @(posedge clk); #1;
    drive_m(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("ar_post_idx",  predict_idxF,  16);
    check("ar_post_take", predict_takeF, 0);
    check("ar_post_cnt",  branch_count,  0);

    // Branch counter wrap.
    for (int k = 0; k < 65535; k++) rand_cycle(1);
    @(posedge clk); #1;
    drive_m(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("wrap_max", branch_count, 16'hFFFF);
    rand_cycle(1);
    @(posedge clk); #1;
    drive_m(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("wrap_zero", branch_count, 0);

    @(negedge clk);
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch direction/target predictor for the five-stage MIPS pipeline. Looks up `pcF` in the fetch stage and produces a taken/target guess for the next-PC mux. Is trained by resolved branches arriving from the memory stage, where it also flags mispredictions and supplies the recovery PC. Gshare pattern history table of 2-bit saturating counters plus a direct-mapped branch target buffer; all state in flops.

## Interface
Parameters:
- `PHT_BITS`, default 6: PHT index width; 64 counters; also global history register (GHR) width.
- `BTB_BITS`, default 4: BTB index width; 16 entries.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `pcF`  in  32  — fetch PC.
- `predict_takeF`  out  1  — predict taken this fetch.
- `predict_targetF`  out  32  — predicted target; valid when `predict_takeF`=1, else 0.
- `predict_idxF`  out  PHT_BITS  — PHT index used; pipeline carries it to M.
- `branchM`  in  1  — one-cycle pulse: a conditional branch resolves in M this cycle.
- `actually_takenM`  in  1  — resolved direction.
- `pcM`  in  32  — PC of the resolving branch.
- `branch_targetM`  in  32  — resolved taken-target.
- `predict_takeM`  in  1  — carried `predict_takeF`.
- `predict_targetM`  in  32  — carried `predict_targetF`.
- `predict_idxM`  in  PHT_BITS  — carried `predict_idxF`.
- `predict_resultM`  out  1  — 1 = prediction correct; 0 when `branchM`=0.
- `mispredictM`  out  1  — `branchM` & ~`predict_resultM`; flush F/D/E, take redirect.
- `redirect_pcM`  out  32  — `actually_takenM` ? `branch_targetM` : `pcM`+4.
- `branch_count`  out  16  — resolved branches since reset; wraps.
- `mispredict_count`  out  16  — mispredictions since reset; wraps.

## Operation
- PHT index at F: `pcF[PHT_BITS+1:2]` XOR GHR. Drives `predict_idxF`.
- BTB index: `pcF[BTB_BITS+1:2]`. Tag: `pcF[31:BTB_BITS+2]`. Hit = valid & tag match.
- `predict_takeF` = BTB hit & counter[1]. `predict_targetF` = hit entry target when taken, else 0.
- Counter encoding: 0 strong-not-taken, 1 weak-not-taken, 2 weak-taken, 3 strong-taken.
- Counter update on `branchM`, at entry `predict_idxM`: taken → +1, saturate at 3; not taken → −1, saturate at 0.
- Never recompute the index at M. GHR may have moved since F.
- GHR update on `branchM`: `{GHR[PHT_BITS-2:0], actually_takenM}`. Non-speculative; no checkpoint or repair needed.
- BTB update on `branchM` & `actually_takenM`: write entry at `pcM` index with valid=1, tag of `pcM`, target `branch_targetM`. Overwrites any alias. Not-taken branches leave the BTB untouched.
- `predict_resultM` = (`predict_takeM` == `actually_takenM`) & (~`actually_takenM` | `predict_targetM` == `branch_targetM`).
- Counters on `branchM`: `branch_count` +1; `mispredict_count` +1 when `mispredictM`. Both wrap 0xFFFF→0.
- `branchM` held for several cycles is illegal. The pipeline pulses it exactly once per branch (gate with ~stallM upstream).

## Timing
- F outputs are combinational from `pcF` and current state; zero latency.
- M outputs (`predict_resultM`, `mispredictM`, `redirect_pcM`) are combinational; zero latency.
- State writes land at the rising edge after `branchM`. The first fetch that sees them is the next cycle.
- Same-cycle fetch of an entry being written reads the old value; no bypass.
- Reset (async, any time, including mid-update) immediately forces:
  - all counters = 1;
  - GHR = 0;
  - all BTB valid = 0;
  - both stats counters = 0.
- Reset outputs with `branchM`=0: `predict_takeF`=0, `predict_targetF`=0, `predict_idxF`=`pcF[PHT_BITS+1:2]`, `mispredictM`=0, `predict_resultM`=0.
- Deassertion is taken synchronously by the integrator; the block itself needs no reset synchronizer.

## Structure
- Package `bp_pkg`:
  - `cnt_t` enum {SNT, WNT, WT, ST} (2 bits);
  - `btb_entry_t` struct {valid, tag, target};
  - default `PHT_BITS`/`BTB_BITS` localparams;
  - `WNT` as counter reset constant.
- Sub-module `bp_btb`: BTB array, hit/target read port, write port, async clear.
- PHT, GHR and stats live in `branch_predictor`.

## Test plan
- Reset, then `pcF`=0x40 → `predict_takeF`=0, `predict_targetF`=0, `branch_count`=0.
- Same branch (`pcM`=0x40, target 0x80), `actually_takenM`=1, resolved twice:
  - 1st: `mispredictM`=1, `redirect_pcM`=0x80.
  - Counter then 2; GHR-adjusted fetch of 0x40 predicts taken to 0x80.
  - 2nd: with carried correct prediction, `predict_resultM`=1.
- Counter saturation: four taken updates at one index hold at 3. One not-taken update gives 2, so the prediction is still taken.
- Not-taken mispredict: `predict_takeM`=1, `actually_takenM`=0, `pcM`=0x100 → `mispredictM`=1, `redirect_pcM`=0x104.
- Target mismatch: taken both ways, `predict_targetM`=0x200, `branch_targetM`=0x240 → `mispredictM`=1, and the BTB holds 0x240 afterwards.
- Counter wrap and reset:
  - 65536 `branchM` pulses → `branch_count` wraps to 0.
  - Assert `rst` low mid-cycle with `branchM`=1 → all state cleared before the next edge, and no update is applied.
